// File: rtl/handshaking_slave_fifo.sv
// Receive side of a valid/ready link: a small first-word fall-through FIFO that
// accepts words from an upstream master and presents them to a downstream consumer.
module handshaking_slave_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [ADDR_WIDTH:0]   count
);

    // Handshake rule on both sides: a word moves on a rising clk edge where its
    // valid and ready are both high; ready never looks at the partner's valid.

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;

    logic w_push;
    logic w_pop;

    assign ready_out = !rst && (r_count != FULL_COUNT);
    assign valid_out = !rst && (r_count != '0);
    assign data_out  = valid_out ? r_mem[r_rd_ptr] : '0;
    assign count     = r_count;

    assign w_push = valid_in && ready_out;
    assign w_pop  = valid_out && ready_in;

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; w_push is already blocked while rst is high.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_handshaking_slave_fifo.sv
// Bench for handshaking_slave_fifo: directed vector table followed by randomized
// traffic checked against a queue-based model of the FIFO.
module tb_handshaking_slave_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_in;
    logic [2:0] count;

    handshaking_slave_fifo #(.DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vin;
        logic [7:0] din;
        logic       rin;
        logic       e_rdy;
        logic       e_vld;
        logic [7:0] e_data;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         total = 0;
    int         bad   = 0;
    bit         last_push;

    task automatic add(input logic r, input logic vi, input logic [7:0] d, input logic ri,
                       input logic er, input logic ev, input logic [7:0] ed, input logic [2:0] ec);
        vec_t v;
        v.rst = r; v.vin = vi; v.din = d; v.rin = ri;
        v.e_rdy = er; v.e_vld = ev; v.e_data = ed; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: the FIFO is a queue; ready/valid follow from its size.
    task automatic model_step();
        bit m_rdy, m_vld, push, pop;
        m_rdy = !rst && (exp_q.size() < DEPTH);
        m_vld = !rst && (exp_q.size() > 0);
        push  = valid_in && m_rdy;
        pop   = m_vld && ready_in;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (push) exp_q.push_back(data_in);
        end
        last_push = push;
    endtask

    task automatic check_model(input string tag);
        logic       m_rdy, m_vld;
        logic [7:0] m_data;
        m_rdy  = !rst && (exp_q.size() != DEPTH);
        m_vld  = !rst && (exp_q.size() != 0);
        m_data = m_vld ? exp_q[0] : 8'h00;
        check({tag, ".ready_out"}, 8'(ready_out), 8'(m_rdy));
        check({tag, ".valid_out"}, 8'(valid_out), 8'(m_vld));
        check({tag, ".data_out"}, data_out, m_data);
        check({tag, ".count"}, 8'(count), 8'(exp_q.size()));
    endtask

    // Drive one cycle: inputs set after the previous edge, outputs sampled at negedge.
    task automatic drive(input logic r, input logic vi, input logic [7:0] d, input logic ri);
        rst = r; valid_in = vi; data_in = d; ready_in = ri;
        @(negedge clk);
    endtask

    task automatic finish_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit         h_vin;
        logic [7:0] h_din;
        int         rin_pct;

        rst = 1'b1; valid_in = 1'b0; data_in = 8'h00; ready_in = 1'b0;
        @(posedge clk);
        #1;
        model_step();

        // rst, vin, din, rin | ready, valid, data, count
        add(1, 0, 8'h00, 0,  0, 0, 8'h00, 0);
        add(0, 0, 8'h00, 0,  1, 0, 8'h00, 0);
        // single word
        add(0, 1, 8'h96, 0,  1, 0, 8'h00, 0);
        add(0, 0, 8'h00, 0,  1, 1, 8'h96, 1);
        add(0, 0, 8'h00, 1,  1, 1, 8'h96, 1);
        add(0, 0, 8'h00, 0,  1, 0, 8'h00, 0);
        // fill, then 8'h05 held off
        add(0, 1, 8'h01, 0,  1, 0, 8'h00, 0);
        add(0, 1, 8'h02, 0,  1, 1, 8'h01, 1);
        add(0, 1, 8'h03, 0,  1, 1, 8'h01, 2);
        add(0, 1, 8'h04, 0,  1, 1, 8'h01, 3);
        add(0, 1, 8'h05, 0,  0, 1, 8'h01, 4);
        add(0, 1, 8'h05, 0,  0, 1, 8'h01, 4);
        // drain from full; pop in the full cycle does not admit 8'h05
        add(0, 1, 8'h05, 1,  0, 1, 8'h01, 4);
        add(0, 1, 8'h05, 1,  1, 1, 8'h02, 3);
        add(0, 0, 8'h00, 1,  1, 1, 8'h03, 3);
        add(0, 0, 8'h00, 1,  1, 1, 8'h04, 2);
        add(0, 0, 8'h00, 1,  1, 1, 8'h05, 1);
        add(0, 0, 8'h00, 0,  1, 0, 8'h00, 0);
        // simultaneous push/pop at count=2 across pointer wrap
        add(0, 1, 8'hA0, 0,  1, 0, 8'h00, 0);
        add(0, 1, 8'hA1, 0,  1, 1, 8'hA0, 1);
        add(0, 1, 8'h10, 1,  1, 1, 8'hA0, 2);
        add(0, 1, 8'h11, 1,  1, 1, 8'hA1, 2);
        add(0, 1, 8'h12, 1,  1, 1, 8'h10, 2);
        add(0, 1, 8'h13, 1,  1, 1, 8'h11, 2);
        add(0, 1, 8'h14, 1,  1, 1, 8'h12, 2);
        add(0, 1, 8'h15, 1,  1, 1, 8'h13, 2);
        add(0, 0, 8'h00, 1,  1, 1, 8'h14, 2);
        add(0, 0, 8'h00, 1,  1, 1, 8'h15, 1);
        add(0, 0, 8'h00, 0,  1, 0, 8'h00, 0);
        // reset mid-stream with push and pop offered
        add(0, 1, 8'h21, 0,  1, 0, 8'h00, 0);
        add(0, 1, 8'h22, 0,  1, 1, 8'h21, 1);
        add(0, 1, 8'h23, 0,  1, 1, 8'h21, 2);
        add(1, 1, 8'h24, 1,  0, 0, 8'h00, 3);
        add(0, 0, 8'h00, 0,  1, 0, 8'h00, 0);
        add(0, 0, 8'h00, 1,  1, 0, 8'h00, 0);
        add(0, 0, 8'h00, 0,  1, 0, 8'h00, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].vin, vecs[i].din, vecs[i].rin);
            check($sformatf("vec%0d.ready_out", i), 8'(ready_out), 8'(vecs[i].e_rdy));
            check($sformatf("vec%0d.valid_out", i), 8'(valid_out), 8'(vecs[i].e_vld));
            check($sformatf("vec%0d.data_out", i), data_out, vecs[i].e_data);
            check($sformatf("vec%0d.count", i), 8'(count), 8'(vecs[i].e_cnt));
            finish_cycle();
        end

        // randomized traffic; upstream holds an offered word until accepted
        h_vin   = 1'b0;
        h_din   = 8'h00;
        rin_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            logic r;
            if (i % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rin_pct = 10;
                    1:       rin_pct = 50;
                    default: rin_pct = 95;
                endcase
            end
            if (!h_vin || last_push) begin
                h_vin = ($urandom_range(0, 3) != 0);
                h_din = 8'($urandom);
            end
            r = ($urandom_range(0, 149) == 0);
            drive(r, h_vin, h_vin ? h_din : 8'($urandom),
                  ($urandom_range(0, 99) < rin_pct));
            check_model("rand");
            finish_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
